// File: rtl/fft_pkg.sv
// Shared FFT datapath types, fixed-point constants and the 16-bit saturation helper.
package fft_pkg;

   typedef logic signed [15:0] sample_t;

   typedef struct packed {
      sample_t re;
      sample_t im;
   } cplx_t;

   typedef logic signed [32:0] prod_t;

   localparam int TW_FRAC_DEF = 14;
   localparam int SAT_MAX     = 32767;
   localparam int SAT_MIN     = -32768;

   function automatic sample_t sat16(input prod_t x);
      if (x > prod_t'(SAT_MAX)) return sample_t'(SAT_MAX);
      if (x < prod_t'(SAT_MIN)) return sample_t'(SAT_MIN);
      return sample_t'(x);
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle table W(k) = cos - j*sin for k in 0..N_POINTS/2-1, built at elaboration.
// Registered read; the output lines up with pipeline stage 1.
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int N_POINTS = 16,
   parameter int TW_FRAC  = TW_FRAC_DEF,
   localparam int HALF    = N_POINTS / 2,
   localparam int KW      = $clog2(HALF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [KW-1:0] k,
   output cplx_t         w
);

   localparam real PI    = 3.14159265358979323846;
   localparam real SCALE = 2.0 ** TW_FRAC;

   // Plain Taylor series keeps table generation within basic real arithmetic.
   function automatic real cos_r(input real x);
      real term;
      real sum;
      term = 1.0;
      sum  = 1.0;
      for (int n = 1; n < 30; n++) begin
         term = -term * x * x / real'((2 * n - 1) * (2 * n));
         sum  = sum + term;
      end
      return sum;
   endfunction

   function automatic real sin_r(input real x);
      real term;
      real sum;
      term = x;
      sum  = x;
      for (int n = 1; n < 30; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return sum;
   endfunction

   function automatic int tw_round(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   sample_t tab_re [HALF];
   sample_t tab_im [HALF];

   for (genvar i = 0; i < HALF; i++) begin : g_tab
      localparam real ANG = 2.0 * PI * real'(i) / real'(N_POINTS);
      localparam int  WR  = tw_round(SCALE * cos_r(ANG));
      localparam int  WS  = tw_round(SCALE * sin_r(ANG));
      assign tab_re[i] = sample_t'(WR);
      assign tab_im[i] = sample_t'(-WS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w <= '0;
      end else if (en) begin
         w.re <= tab_re[k];
         w.im <= tab_im[k];
      end
   end

endmodule

// File: rtl/twiddle_mult.sv
// Three-stage FFT twiddle multiplier: b-leg times W(k), a-leg delayed to match.
// Build macro TWIDDLE_ROUND_EN selects round-half-up before the shift; default truncates.
module twiddle_mult
   import fft_pkg::*;
#(
   parameter int N_POINTS = 16,
   parameter int TW_FRAC  = TW_FRAC_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sof,
   input  logic signed [15:0]   in_real_a,
   input  logic signed [15:0]   in_complex_a,
   input  logic signed [15:0]   in_real_b,
   input  logic signed [15:0]   in_complex_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sof,
   output logic signed [15:0]   out_real_a,
   output logic signed [15:0]   out_complex_a,
   output logic signed [15:0]   out_real_b,
   output logic signed [15:0]   out_complex_b
);

   localparam int            HALF   = N_POINTS / 2;
   localparam int            KW     = $clog2(HALF);
   localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);
`ifdef TWIDDLE_ROUND_EN
   localparam prod_t         RND    = prod_t'(1) <<< (TW_FRAC - 1);
`else
   localparam prod_t         RND    = '0;
`endif

   logic          en;
   logic          accept;
   logic [KW-1:0] k;
   logic [KW-1:0] k_use;

   logic          s1_valid, s1_sof;
   cplx_t         s1_a, s1_b, s1_w;
   logic          s2_valid, s2_sof;
   cplx_t         s2_a;
   prod_t         s2_re, s2_im;

   logic signed [31:0] m_rr, m_ii, m_ri, m_ir;
   prod_t              r_re, r_im;

   // One global enable: the whole pipe advances only when the output slot frees.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;
   assign k_use    = in_sof ? '0 : k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k <= '0;
      end else if (accept) begin
         k <= (k_use == K_LAST) ? '0 : k_use + KW'(1);
      end
   end

   twiddle_rom #(
      .N_POINTS (N_POINTS),
      .TW_FRAC  (TW_FRAC)
   ) u_rom (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .k   (k_use),
      .w   (s1_w)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_sof   <= in_sof && in_valid;
         s1_a     <= '{re: in_real_a, im: in_complex_a};
         s1_b     <= '{re: in_real_b, im: in_complex_b};
      end
   end

   assign m_rr = 32'($signed(s1_b.re)) * 32'($signed(s1_w.re));
   assign m_ii = 32'($signed(s1_b.im)) * 32'($signed(s1_w.im));
   assign m_ri = 32'($signed(s1_b.re)) * 32'($signed(s1_w.im));
   assign m_ir = 32'($signed(s1_b.im)) * 32'($signed(s1_w.re));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_a     <= '0;
         s2_re    <= '0;
         s2_im    <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
         s2_a     <= s1_a;
         s2_re    <= 33'(m_rr) - 33'(m_ii);
         s2_im    <= 33'(m_ri) + 33'(m_ir);
      end
   end

   assign r_re = (s2_re + RND) >>> TW_FRAC;
   assign r_im = (s2_im + RND) >>> TW_FRAC;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_sof       <= 1'b0;
         out_real_a    <= '0;
         out_complex_a <= '0;
         out_real_b    <= '0;
         out_complex_b <= '0;
      end else if (en) begin
         out_valid     <= s2_valid;
         out_sof       <= s2_sof;
         out_real_a    <= s2_a.re;
         out_complex_a <= s2_a.im;
         out_real_b    <= sat16(r_re);
         out_complex_b <= sat16(r_im);
      end
   end

endmodule

// File: tb/tb_twiddle_mult.sv
// Self-checking bench for twiddle_mult (N_POINTS=16, TW_FRAC=14) against a real-arithmetic model.
`timescale 1ns/1ps
module tb_twiddle_mult;

   localparam int N    = 16;
   localparam int TWF  = 14;
   localparam int HALF = N / 2;

   typedef logic signed [15:0] s16_t;
   typedef struct packed {
      logic        sof;
      logic [15:0] ar, ai, br, bi;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, in_sof;
   s16_t in_real_a, in_complex_a, in_real_b, in_complex_b;
   logic out_valid, out_ready, out_sof;
   s16_t out_real_a, out_complex_a, out_real_b, out_complex_b;

   twiddle_mult #(.N_POINTS(N), .TW_FRAC(TWF)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sof        (in_sof),
      .in_real_a     (in_real_a),
      .in_complex_a  (in_complex_a),
      .in_real_b     (in_real_b),
      .in_complex_b  (in_complex_b),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sof       (out_sof),
      .out_real_a    (out_real_a),
      .out_complex_a (out_complex_a),
      .out_real_b    (out_real_b),
      .out_complex_b (out_complex_b)
   );

   always #5 clk = ~clk;

   obs_t exp_q[$];
   obs_t got_q[$];
   obs_t want_q[$];
   int   k_m;
   int   n_acc;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic int rnd_int(input real x);
      return (x >= 0.0) ? $rtoi($floor(x + 0.5)) : -$rtoi($floor(0.5 - x));
   endfunction

   function automatic int tw_cos(input int k);
      return rnd_int((2.0 ** TWF) * $cos(2.0 * 3.14159265358979 * real'(k) / real'(N)));
   endfunction

   function automatic int tw_sin(input int k);
      return rnd_int((2.0 ** TWF) * $sin(2.0 * 3.14159265358979 * real'(k) / real'(N)));
   endfunction

   function automatic logic [15:0] fix(input longint p);
      real q;
`ifdef TWIDDLE_ROUND_EN
      q = $floor(real'(p) / (2.0 ** TWF) + 0.5);
`else
      q = $floor(real'(p) / (2.0 ** TWF));
`endif
      if (q > 32767.0)  q = 32767.0;
      if (q < -32768.0) q = -32768.0;
      return 16'($rtoi(q));
   endfunction

   function automatic obs_t model(input logic sof, input int ar, ai, br, bi, k);
      longint wr, wi;
      obs_t   o;
      wr   = longint'(tw_cos(k));
      wi   = -longint'(tw_sin(k));
      o.sof = sof;
      o.ar  = 16'(ar);
      o.ai  = 16'(ai);
      o.br  = fix(longint'(br) * wr - longint'(bi) * wi);
      o.bi  = fix(longint'(br) * wi + longint'(bi) * wr);
      return o;
   endfunction

   // One clock of stimulus; records accepted inputs into the model and consumed outputs.
   task automatic cycle(input logic iv, isof, input int ar, ai, br, bi, input logic ordy);
      int idx;
      @(negedge clk);
      in_valid     = iv;
      in_sof       = isof;
      in_real_a    = s16_t'(ar);
      in_complex_a = s16_t'(ai);
      in_real_b    = s16_t'(br);
      in_complex_b = s16_t'(bi);
      out_ready    = ordy;
      #1;
      if (in_valid && in_ready) begin
         idx = isof ? 0 : k_m;
         exp_q.push_back(model(isof, ar, ai, br, bi, idx));
         k_m = (idx + 1) % HALF;
         n_acc++;
      end
      if (out_valid && out_ready) begin
         got_q.push_back({out_sof, out_real_a, out_complex_a, out_real_b, out_complex_b});
         want_q.push_back(exp_q.size() > 0 ? exp_q.pop_front() : obs_t'('x));
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic clear_logs();
      got_q.delete();
      want_q.delete();
      n_acc = 0;
   endtask

   function automatic int rs16();
      return int'(s16_t'($urandom));
   endfunction

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      in_real_a = '0; in_complex_a = '0; in_real_b = '0; in_complex_b = '0;
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_sof !== 1'b0)
         begin n_fail++; $display("FAIL reset_ctrl: got valid=%b sof=%b, want 0 0", out_valid, out_sof); end
      n_tests++;
      if ({out_real_a, out_complex_a, out_real_b, out_complex_b} !== 64'd0)
         begin n_fail++; $display("FAIL reset_data: got %h, want 0", {out_real_a, out_complex_a, out_real_b, out_complex_b}); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1)
         begin n_fail++; $display("FAIL reset_ready: got %b, want 1", in_ready); end
      exp_q.delete(); k_m = 0;
   endtask

   task automatic test_latency();
      obs_t want;
      clear_logs();
      want = '{sof: 1'b1, ar: 16'd7, ai: 16'hFFF9, br: 16'd1000, bi: 16'd500};
      cycle(1, 1, 7, -7, 1000, 500, 1);
      for (int i = 1; i <= 3; i++) begin
         cycle(0, 0, 0, 0, 0, 0, 1);
         n_tests++;
         if (out_valid !== (i == 3))
            begin n_fail++; $display("FAIL latency_c%0d: got valid=%b, want %b", i, out_valid, i == 3); end
      end
      n_tests++;
      if (got_q.size() != 1 || got_q[0] !== want)
         begin n_fail++; $display("FAIL sof_pair: got n=%0d %h, want %h", got_q.size(), got_q.size() ? got_q[0] : obs_t'('x), want); end
   endtask

   task automatic test_sweep_wrap();
      clear_logs();
      for (int j = 0; j < 9; j++) cycle(1, j == 0, rs16(), rs16(), 16384, 0, 1);
      drain();
      n_tests++;
      if (got_q.size() != 9)
         begin n_fail++; $display("FAIL sweep_count: got %0d, want 9", got_q.size()); end
      foreach (got_q[j]) begin
         n_tests++;
         if (got_q[j].br !== 16'(tw_cos(j % HALF)) || got_q[j] !== want_q[j])
            begin n_fail++; $display("FAIL sweep_k%0d: got %h, want br=%h full %h", j, got_q[j], 16'(tw_cos(j % HALF)), want_q[j]); end
      end
   endtask

   task automatic test_saturate();
      clear_logs();
      cycle(1, 1, 1, 2, 100, 100, 1);
      cycle(1, 0, 3, 4, 200, -200, 1);
      cycle(1, 0, 5, 6, 32767, -32767, 1);
      drain();
      n_tests++;
      if (got_q.size() != 3 || got_q[2].br !== 16'd0 || got_q[2].bi !== 16'h8000)
         begin n_fail++; $display("FAIL sat_k2: got n=%0d b=%h, want b=(0000,8000)", got_q.size(), got_q.size() > 2 ? {got_q[2].br, got_q[2].bi} : 32'hx); end
      foreach (got_q[j]) begin
         n_tests++;
         if (got_q[j] !== want_q[j])
            begin n_fail++; $display("FAIL sat_model%0d: got %h, want %h", j, got_q[j], want_q[j]); end
      end
   endtask

   task automatic test_round();
      logic [15:0] want;
`ifdef TWIDDLE_ROUND_EN
      want = 16'd3;
`else
      want = 16'd2;
`endif
      clear_logs();
      cycle(1, 1, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 3, 0, 1);
      drain();
      n_tests++;
      if (got_q.size() != 2 || got_q[1].br !== want)
         begin n_fail++; $display("FAIL round_k1: got %h, want %h", got_q.size() > 1 ? got_q[1].br : 16'hx, want); end
   endtask

   task automatic test_stall();
      obs_t prev, now;
      bit   have_prev;
      logic ordy;
      clear_logs();
      have_prev = 0;
      for (int i = 0; i < 20; i++) begin
         ordy = !(i >= 6 && i < 11);
         cycle(1, i == 0, rs16(), rs16(), rs16(), rs16(), ordy);
         now = {out_sof, out_real_a, out_complex_a, out_real_b, out_complex_b};
         if (!ordy && out_valid) begin
            n_tests++;
            if (in_ready !== 1'b0)
               begin n_fail++; $display("FAIL stall_ready%0d: got %b, want 0", i, in_ready); end
            if (have_prev) begin
               n_tests++;
               if (now !== prev)
                  begin n_fail++; $display("FAIL stall_hold%0d: got %h, want %h", i, now, prev); end
            end
            prev = now; have_prev = 1;
         end else have_prev = 0;
      end
      drain();
      n_tests++;
      if (got_q.size() != n_acc || exp_q.size() != 0)
         begin n_fail++; $display("FAIL stall_count: got %0d out, want %0d", got_q.size(), n_acc); end
      foreach (got_q[j]) begin
         n_tests++;
         if (got_q[j] !== want_q[j])
            begin n_fail++; $display("FAIL stall_data%0d: got %h, want %h", j, got_q[j], want_q[j]); end
      end
   endtask

   task automatic test_random();
      int bad;
      clear_logs();
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
               rs16(), rs16(), rs16(), rs16(), $urandom_range(0, 9) < 7);
      drain();
      n_tests++;
      if (got_q.size() != n_acc || exp_q.size() != 0)
         begin n_fail++; $display("FAIL rand_count: got %0d out, want %0d", got_q.size(), n_acc); end
      bad = 0;
      foreach (got_q[j]) begin
         n_tests++;
         if (got_q[j] !== want_q[j]) begin
            n_fail++;
            if (bad++ < 5) $display("FAIL rand_data%0d: got %h, want %h", j, got_q[j], want_q[j]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      clear_logs();
      cycle(1, 1, 1, 1, 100, 0, 1);
      cycle(1, 0, 2, 2, 100, 0, 1);
      cycle(1, 0, 3, 3, 100, 0, 1);
      @(posedge clk);
      #2;
      n_tests++;
      if (out_valid !== 1'b1)
         begin n_fail++; $display("FAIL mid_pre: got valid=%b, want 1", out_valid); end
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || {out_sof, out_real_a, out_complex_a, out_real_b, out_complex_b} !== 65'd0)
         begin n_fail++; $display("FAIL mid_async: got valid=%b data=%h, want 0", out_valid, {out_real_a, out_complex_a, out_real_b, out_complex_b}); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete(); k_m = 0;
      clear_logs();
      cycle(1, 0, 9, -9, 16384, 0, 1);
      drain();
      n_tests++;
      if (got_q.size() != 1 || got_q[0] !== obs_t'{1'b0, 16'd9, 16'hFFF7, 16'd16384, 16'd0})
         begin n_fail++; $display("FAIL mid_k0: got n=%0d %h, want 0_0009_fff7_4000_0000", got_q.size(), got_q.size() ? got_q[0] : obs_t'('x)); end
   endtask

   initial begin
      k_m = 0; n_acc = 0;
      test_reset();
      test_latency();
      test_sweep_wrap();
      test_saturate();
      test_round();
      test_stall();
      test_random();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
